// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Walks a program stored in an external instruction memory. Each instruction
// is fetched, captured into the code register, given one decode cycle, and then
// issued. Executable opcodes launch the execution unit and wait for its
// completion, with a bounded wait. Opcode 0 is a NOP and the all-ones opcode
// is HALT.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   start       begin a program (sampled only while idle)
//   prog_len    instruction count, sampled together with start
//   mem_rd_en   instruction memory read strobe
//   mem_addr    instruction memory address (current program counter)
//   mem_data    memory read data, valid the cycle after mem_rd_en
//   code        registered instruction word driven to the decoder
//   exec_start  one-cycle launch pulse to the execution unit
//   exec_done   execution unit completion
//   busy        high whenever not idle
//   done        one-cycle pulse at program end
//   error       sticky timeout flag, cleared by reset or the next start
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned OP_SIZE      = 4,
  parameter int unsigned PARAM_A_SIZE = 4,
  parameter int unsigned PARAM_B_SIZE = 4,
  parameter int unsigned ADDR_SIZE    = 8,
  parameter int unsigned TIMEOUT      = 255   // must be at least 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [ADDR_SIZE-1:0]                         prog_len,
  output logic                                         mem_rd_en,
  output logic [ADDR_SIZE-1:0]                         mem_addr,
  input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] mem_data,
  output logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] code,
  output logic                                         exec_start,
  input  logic                                         exec_done,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         error
);

  localparam int unsigned CW    = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // The counter holds the number of wait cycles already elapsed, so the
  // TIMEOUT-th wait cycle is the one where it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    DECODE,
    ISSUE,
    WAIT_EXEC,
    FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_SIZE-1:0]  pc_q,    pc_d;
  logic [ADDR_SIZE-1:0]  len_q,   len_d;
  logic [CW-1:0]         code_q,  code_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  error_q, error_d;

  logic [OP_SIZE-1:0]    opcode;
  logic                  is_halt;
  logic                  is_nop;
  logic [ADDR_SIZE-1:0]  last_pc;
  logic                  adv;

  assign opcode  = code_q[CW-1 -: OP_SIZE];
  assign is_halt = &opcode;
  assign is_nop  = (opcode == '0);
  // len_q is never zero while an instruction is in flight.
  assign last_pc = len_q - 1'b1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    adv     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (prog_len == '0) begin
            state_d = FINISH;
          end else begin
            state_d = FETCH;
            pc_d    = '0;
            len_d   = prog_len;
          end
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        code_d  = mem_data;
        state_d = DECODE;
      end
      DECODE:  state_d = ISSUE;
      ISSUE: begin
        if (is_halt) begin
          state_d = FINISH;
        end else if (is_nop) begin
          adv = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_EXEC;
        end
      end
      WAIT_EXEC: begin
        // Completion wins over timeout when both land on the last wait cycle.
        if (exec_done) begin
          adv = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (pc_q == last_pc) begin
        state_d = FINISH;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = FETCH;
      end
    end
  end

  // Output logic
  always_comb begin
    mem_rd_en  = (state_q == FETCH);
    exec_start = (state_q == ISSUE) && !is_halt && !is_nop;
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
  end

  assign mem_addr = pc_q;
  assign code     = code_q;
  assign error    = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam int TO = 6;

  localparam int EV_FETCH = 0;
  localparam int EV_CODE  = 1;
  localparam int EV_EXEC  = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int          kind;
    logic [11:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  prog_len = '0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [11:0] mem_data = '0;
  logic [11:0] code;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic        busy;
  logic        done;
  logic        error;

  logic [11:0] mem [16];

  ev_t   q[$];
  string nm[4] = '{"FETCH", "CODE", "EXEC", "DONE"};
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    st_cyc = 0;
  int    fetch_t[$];
  int    exec_t = 0;
  int    done_t = 0;
  int    n_exec = 0;
  int    n_done = 0;
  logic [11:0] code_prev = '0;

  int resp_delay = 1;
  int resp_hold  = 1;
  int resp_limit = 0;
  int resp_used  = 0;

  instr_sequencer #(
    .OP_SIZE(4),
    .PARAM_A_SIZE(4),
    .PARAM_B_SIZE(4),
    .ADDR_SIZE(8),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .prog_len(prog_len),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .code(code),
    .exec_start(exec_start),
    .exec_done(exec_done),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: one-cycle read latency
  initial forever begin
    @(posedge clk);
    if (mem_rd_en) mem_data <= mem[mem_addr[3:0]];
  end

  // Execution unit model: answers exec_start after resp_delay edges, holding
  // exec_done for resp_hold cycles, while its response budget lasts.
  initial forever begin
    @(negedge clk);
    if (exec_start === 1'b1 && resp_used < resp_limit) begin
      resp_used++;
      repeat (resp_delay) @(posedge clk);
      #1 exec_done = 1'b1;
      repeat (resp_hold) @(posedge clk);
      #1 exec_done = 1'b0;
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [11:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [11:0] v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s=%h at cycle %0d, required none", nm[k], v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val !== v) begin
        errors++;
        $display("FAIL event_order: got %s=%h at cycle %0d, required %s=%h",
                 nm[k], v, cyc, nm[e.kind], e.val);
      end
    end
  endtask

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (mem_rd_en === 1'b1) begin
      check_ev(EV_FETCH, {4'h0, mem_addr});
      fetch_t.push_back(cyc);
    end
    if (code !== code_prev) begin
      check_ev(EV_CODE, code);
      code_prev = code;
    end
    if (exec_start === 1'b1) begin
      check_ev(EV_EXEC, code);
      exec_t = cyc;
      n_exec++;
    end
    if (done === 1'b1) begin
      check_ev(EV_DONE, {11'h0, error});
      done_t = cyc;
      n_done++;
    end
  end

  task automatic load4(input logic [11:0] w0, input logic [11:0] w1,
                       input logic [11:0] w2, input logic [11:0] w3);
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    mem[3] = w3;
  endtask

  task automatic responder(input int dly, input int hold, input int n);
    resp_delay = dly;
    resp_hold  = hold;
    resp_limit = resp_used + n;
  endtask

  task automatic run_prog(input logic [7:0] n);
    fetch_t.delete();
    @(posedge clk);
    #1 start = 1'b1;
    prog_len = n;
    st_cyc   = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    prog_len = 8'h00;
  endtask

  task automatic wait_done(input string name);
    int  d0;
    bit  seen;
    d0   = n_done;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (n_done != d0) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done pulse, required one within 2000 cycles", name);
    end
    chk({name, "_leftover"}, q.size(), 0);
    q.delete();
  endtask

  function automatic int fdelta(input int a, input int b);
    if (fetch_t.size() <= b) return -1;
    return fetch_t[b] - fetch_t[a];
  endfunction

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_exec_start", exec_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_code", code, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Three instructions: exec, NOP, exec
    load4(12'h112, 12'h000, 12'h234, 12'h000);
    responder(1, 1, 10);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_CODE, 12'h112); expect_ev(EV_EXEC, 12'h112);
    expect_ev(EV_FETCH, 12'h001); expect_ev(EV_CODE, 12'h000);
    expect_ev(EV_FETCH, 12'h002); expect_ev(EV_CODE, 12'h234); expect_ev(EV_EXEC, 12'h234);
    expect_ev(EV_DONE, 12'h000);
    run_prog(8'd3);
    chk("p3_busy_after_start", busy, 1);
    wait_done("p3");
    chk("p3_first_fetch_latency", fetch_t[0] - st_cyc, 1);
    chk("p3_exec_instr_cycles", fdelta(0, 1), 5);
    chk("p3_nop_instr_cycles", fdelta(1, 2), 4);
    chk("p3_last_to_done", done_t - fetch_t[2], 5);

    // HALT at word 1 stops the program
    load4(12'h112, 12'hF00, 12'h345, 12'h456);
    responder(1, 1, 10);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_CODE, 12'h112); expect_ev(EV_EXEC, 12'h112);
    expect_ev(EV_FETCH, 12'h001); expect_ev(EV_CODE, 12'hF00);
    expect_ev(EV_DONE, 12'h000);
    run_prog(8'd4);
    wait_done("halt");
    chk("halt_to_done", done_t - fetch_t[1], 4);

    // Execution unit never answers
    load4(12'h123, 12'h000, 12'h000, 12'h000);
    responder(1, 1, 0);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_CODE, 12'h123); expect_ev(EV_EXEC, 12'h123);
    expect_ev(EV_DONE, 12'h001);
    run_prog(8'd1);
    wait_done("tmo");
    chk("tmo_exec_to_done", done_t - exec_t, TO + 1);
    @(posedge clk);
    #1;
    chk("tmo_error_sticky", error, 1);
    chk("tmo_idle_busy", busy, 0);

    // A new start clears the error
    responder(1, 1, 10);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_EXEC, 12'h123); expect_ev(EV_DONE, 12'h000);
    run_prog(8'd1);
    chk("restart_error_cleared", error, 0);
    wait_done("restart");

    // Empty program
    expect_ev(EV_DONE, 12'h000);
    run_prog(8'd0);
    wait_done("len0");
    chk("len0_done_latency", done_t - st_cyc, 1);

    // Completion on the very last wait cycle is not a timeout
    load4(12'h1AB, 12'h2CD, 12'h000, 12'h000);
    responder(TO, 1, 10);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_CODE, 12'h1AB); expect_ev(EV_EXEC, 12'h1AB);
    expect_ev(EV_FETCH, 12'h001); expect_ev(EV_CODE, 12'h2CD); expect_ev(EV_EXEC, 12'h2CD);
    expect_ev(EV_DONE, 12'h000);
    run_prog(8'd2);
    wait_done("edge");
    chk("edge_instr_cycles", fdelta(0, 1), 4 + TO);
    chk("edge_exec_to_done", done_t - exec_t, TO + 1);

    // exec_done held into FETCH/CAPTURE/DECODE must not advance anything
    responder(1, 3, 10);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_CODE, 12'h1AB); expect_ev(EV_EXEC, 12'h1AB);
    expect_ev(EV_FETCH, 12'h001); expect_ev(EV_CODE, 12'h2CD); expect_ev(EV_EXEC, 12'h2CD);
    expect_ev(EV_DONE, 12'h000);
    run_prog(8'd2);
    wait_done("stray");
    chk("stray_instr_cycles", fdelta(0, 1), 5);
    chk("stray_last_to_done", done_t - fetch_t[1], 5);

    // One cycle too late: timeout, late exec_done lands in FINISH
    load4(12'h3C4, 12'h000, 12'h000, 12'h000);
    responder(TO + 1, 1, 10);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_CODE, 12'h3C4); expect_ev(EV_EXEC, 12'h3C4);
    expect_ev(EV_DONE, 12'h001);
    run_prog(8'd1);
    wait_done("late");
    chk("late_exec_to_done", done_t - exec_t, TO + 1);
    @(posedge clk);
    #1;
    chk("late_idle_busy", busy, 0);

    // Reset during WAIT_EXEC of instruction 2, with an ignored start while busy
    load4(12'h112, 12'h234, 12'h345, 12'h000);
    responder(1, 1, 1);
    expect_ev(EV_FETCH, 12'h000); expect_ev(EV_CODE, 12'h112); expect_ev(EV_EXEC, 12'h112);
    expect_ev(EV_FETCH, 12'h001); expect_ev(EV_CODE, 12'h234); expect_ev(EV_EXEC, 12'h234);
    begin
      int  base;
      bit  seen;
      base = n_exec;
      seen = 0;
      run_prog(8'd3);
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        if (n_exec >= base + 2) begin
          seen = 1;
          break;
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rst_mid_wait_timeout: got %0d exec pulses, required 2", n_exec - base);
      end
    end
    #1 start = 1'b1;
    prog_len = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    prog_len = 8'd0;
    chk("busy_start_ignored", busy, 1);
    chk("busy_start_pc", mem_addr, 1);
    expect_ev(EV_CODE, 12'h000);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_rd_en", mem_rd_en, 0);
    chk("midrst_exec_start", exec_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_code", code, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mem_rd_en", mem_rd_en, 0);
    chk("post_rst_leftover", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
